sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single external asynchronous SRAM port between the video scanout fetcher and the CPU load/store path. Sits between `ico_soc`'s two memory requesters and the `sram_a` / `sram_wr` / `host_to_sram` / `sram_to_host` pad signals in the top level. Video gets priority so scanout never misses a deadline; a starvation counter guarantees CPU progress. All SRAM-facing outputs are registered, so the top level's write-strobe gating against `clk_core90` sees glitch-free values.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: SRAM word-address width.
- `VID_BURST`, 4: maximum consecutive video grants while `cpu_req` is pending; range 1–15.

Ports:
- `clk_core`  in  1  core clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `vid_req`  in  1  video read request; held until granted.
- `vid_addr`  in  ADDR_WIDTH  video word address.
- `vid_gnt`  out  1  video request accepted this cycle (combinational).
- `vid_rvalid`  out  1  `rdata` holds video read data.
- `cpu_req`  in  1  CPU request; held until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_WIDTH  CPU word address.
- `cpu_wdata`  in  16  CPU write data.
- `cpu_gnt`  out  1  CPU request accepted this cycle (combinational).
- `cpu_rvalid`  out  1  `rdata` holds CPU read data.
- `rdata`  out  16  shared read-return bus.
- `sram_a`  out  ADDR_WIDTH  registered SRAM address.
- `sram_wr`  out  1  registered write cycle indicator.
- `host_to_sram`  out  16  registered write data.
- `sram_to_host`  in  16  SRAM data pins (unregistered).

## Operation
- Transfer on a port occurs in cycle N when `req && gnt`. The requester may change `addr`/`we`/`wdata` or drop `req` from N+1.
- Grant rule in cycle N, in priority order:
  - With a turnaround block active (see Configuration), no read is granted.
  - If `vid_req`, `cpu_req` and `starve_cnt == VID_BURST`, the CPU wins.
  - Otherwise, if `vid_req`, video wins.
  - Otherwise, if `cpu_req`, the CPU wins.
  - Otherwise there is no grant.
- At most one of `vid_gnt` / `cpu_gnt` is high in any cycle. Both are 0 while `reset` is high.
- `starve_cnt` (4 bits):
  - Increments on a video grant while `cpu_req` is high.
  - Clears on a CPU grant, or in any cycle where `cpu_req` is low.
  - Saturates at `VID_BURST`.
- Access-state register `last` takes one of IDLE, RD or WR:
  - RD after a granted read; WR after a granted write; IDLE with no grant.
  - It describes the access that is on the pins in N+1.
- Pin drive in N+1:
  - Granted access: `sram_a` = granted address, `sram_wr` = `cpu_we` (video is always a read), `host_to_sram` = `cpu_wdata` on a write.
  - No grant: `sram_wr` = 0, and `sram_a` / `host_to_sram` hold their previous values.
- Read return:
  - `sram_to_host` is sampled at the end of N+1 into `rdata`.
  - The owner's `rvalid` pulses for exactly one cycle in N+2.
  - The owner is tracked by a 2-stage pipeline tag.
- Writes produce no `rvalid`.
- Reset values: `sram_a` = 0, `sram_wr` = 0, `host_to_sram` = 0, `rdata` = 0, both `rvalid` = 0, `starve_cnt` = 0, `last` = IDLE.
- Reset asserted mid-access: in-flight pipeline tags are cleared, and no `rvalid` is emitted for an access granted before reset.

## Timing
- Read latency: grant in N → `rvalid` in N+2; the port sustains one access per cycle.
- Back-to-back reads from different owners return in grant order, one per cycle.
- Write: on the pins in N+1, with `sram_wr` high for exactly one cycle per granted write.
- Simultaneous requests with `starve_cnt < VID_BURST`: video is granted and the CPU waits.
- Continuous `vid_req` and `cpu_req`: the grant pattern is VID_BURST video grants, then 1 CPU grant, repeating.

## Configuration
- `SRAM_ARB_TURNAROUND_EN` defined:
  - If the access granted in N is a write, no read (either port) is granted in N+1. That cycle stays idle, or is used by a further CPU write.
  - This gives the data bus one dead cycle between driving and the SRAM's output enable.
- Undefined: reads may be granted immediately after a write, and no idle cycle is inserted.

## Structure
- Shared header `sram_defs.vh`: data width 16, owner tag encodings (NONE / VID / CPU), access-state encodings (IDLE / RD / WR).
- Sub-module `sram_arb_pick`: purely combinational grant selection from the two `req` signals, `starve_cnt`, `VID_BURST` and the turnaround block. Counter, pin registers and return pipeline stay in `sram_arbiter`.

## Test plan
- **Single CPU write, then read:** `cpu_req`, `we` = 1, `addr` = 0x0123, `wdata` = 0xBEEF. Expect `sram_wr` = 1 and `sram_a` = 0x0123 for one cycle. Then a read of 0x0123 with the SRAM model returning 0xBEEF: `cpu_rvalid` in N+2 with `rdata` = 0xBEEF.
- **Contention:** `vid_req` and `cpu_req` (read) both held high, `VID_BURST` = 4. Grants are V,V,V,V,C,V,V,V,V,C. Each `rvalid` arrives exactly 2 cycles after its grant, with the correct owner.
- **Turnaround:** with the macro defined, CPU write in N, then `vid_req` high. `vid_gnt` = 0 in N+1 and 1 in N+2. Without the macro, `vid_gnt` = 1 in N+1.
- **Reset mid-read:** grant a video read, assert `reset` in N+1. `vid_rvalid` stays 0, and all SRAM outputs are 0 on the cycle after reset.
- **Idle hold:** no requests after a read of 0x1FFF. `sram_a` stays 0x1FFF, `sram_wr` = 0, and no `rvalid`.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared data width, read-return owner tags and access-state encodings.
package sram_arbiter_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_e;
  typedef enum logic [1:0] {ACC_IDLE, ACC_RD, ACC_WR} acc_e;
endpackage

// File: rtl/sram_arbiter_pick.sv
// sram_arb_pick: combinational grant selection, video first unless the CPU has starved VID_BURST grants.
module sram_arb_pick
  import sram_arbiter_pkg::*;
#(
  parameter int VID_BURST = 4
) (
  input  logic       vid_req_i,
  input  logic       cpu_req_i,
  input  logic       cpu_we_i,
  input  logic [3:0] starve_cnt_i,
  input  logic       blk_i,
  output logic       vid_gnt_o,
  output logic       cpu_gnt_o
);
  logic force_cpu;
  assign force_cpu = vid_req_i && cpu_req_i && starve_cnt_i == 4'(VID_BURST);
  assign vid_gnt_o = vid_req_i && !force_cpu && !blk_i;
  // During a turnaround block only a further CPU write may use the port.
  assign cpu_gnt_o = cpu_req_i && !vid_gnt_o && !(blk_i && !cpu_we_i);
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM port between video scanout and CPU with registered pin outputs.
// Define SRAM_ARB_TURNAROUND_EN to forbid reads in the cycle right after a granted write.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int VID_BURST  = 4
) (
  input  logic                  clk_core,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_wr,
  output logic [DATA_W-1:0]     host_to_sram,
  input  logic [DATA_W-1:0]     sram_to_host
);
`ifdef SRAM_ARB_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif
  logic [3:0] starve_q, starve_d;
  acc_e last_q, last_d;
  tag_e tag1_q, tag2_q, tag_d;
  logic [ADDR_WIDTH-1:0] sram_a_q;
  logic [DATA_W-1:0] hts_q, rdata_q;
  logic sram_wr_q, blk;
  assign blk = TURN && last_q == ACC_WR;
  sram_arb_pick #(.VID_BURST(VID_BURST)) u_pick (
    .vid_req_i   (vid_req && !reset),
    .cpu_req_i   (cpu_req && !reset),
    .cpu_we_i    (cpu_we),
    .starve_cnt_i(starve_q),
    .blk_i       (blk),
    .vid_gnt_o   (vid_gnt),
    .cpu_gnt_o   (cpu_gnt)
  );
  always_comb begin
    starve_d = (!cpu_req || cpu_gnt) ? 4'd0 :
               (vid_gnt && starve_q != 4'(VID_BURST)) ? starve_q + 4'd1 : starve_q;
    last_d   = (cpu_gnt && cpu_we) ? ACC_WR : (vid_gnt || cpu_gnt) ? ACC_RD : ACC_IDLE;
    tag_d    = vid_gnt ? TAG_VID : (cpu_gnt && !cpu_we) ? TAG_CPU : TAG_NONE;
  end
  always_ff @(posedge clk_core) begin
    if (reset) begin
      starve_q  <= '0;
      last_q    <= ACC_IDLE;
      tag1_q    <= TAG_NONE;
      tag2_q    <= TAG_NONE;
      sram_a_q  <= '0;
      sram_wr_q <= 1'b0;
      hts_q     <= '0;
      rdata_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      last_q    <= last_d;
      tag1_q    <= tag_d;
      tag2_q    <= tag1_q;
      sram_wr_q <= cpu_gnt && cpu_we;
      if (vid_gnt) sram_a_q <= vid_addr;
      else if (cpu_gnt) sram_a_q <= cpu_addr;
      if (cpu_gnt && cpu_we) hts_q <= cpu_wdata;
      // rdata only moves when a read is on the pins, so it holds between returns.
      if (tag1_q != TAG_NONE) rdata_q <= sram_to_host;
    end
  end
  assign sram_a       = sram_a_q;
  assign sram_wr      = sram_wr_q;
  assign host_to_sram = hts_q;
  assign rdata        = rdata_q;
  assign vid_rvalid   = tag2_q == TAG_VID;
  assign cpu_rvalid   = tag2_q == TAG_CPU;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with a per-cycle reference model and hand-computed spot checks.
module tb_sram_arbiter;
  localparam int AW = 13;
  localparam int VB = 4;
`ifdef SRAM_ARB_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif
  logic clk_core = 1'b0, reset = 1'b1;
  logic vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, sram_wr;
  logic [15:0] rdata, host_to_sram, sram_to_host;
  logic [AW-1:0] sram_a;
  logic [15:0] mem [1<<AW];
  logic [15:0] mmem [1<<AW];
  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk_core = ~clk_core;

  sram_arbiter #(.ADDR_WIDTH(AW), .VID_BURST(VB)) dut (
    .clk_core(clk_core), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
    .sram_a(sram_a), .sram_wr(sram_wr), .host_to_sram(host_to_sram), .sram_to_host(sram_to_host)
  );

  // Asynchronous SRAM: combinational read, write committed at the end of the strobe cycle.
  assign sram_to_host = mem[sram_a];
  always @(posedge clk_core) if (sram_wr) mem[sram_a] <= host_to_sram;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: grants from the priority rules, pins from the last grant, reads as a queue of due returns.
  typedef struct {int due; bit vid; logic [15:0] data;} ret_t;
  ret_t rq[$];
  int m_starve = 0;
  bit m_lastwr = 1'b0, m_wr = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [15:0] m_hts = '0, m_rdata = '0;

  always @(negedge clk_core) if (chk_en) begin
    bit blk, frc, gv, gc, ev, ec;
    blk = TURN && m_lastwr;
    frc = vid_req && cpu_req && m_starve == VB;
    gv = !reset && vid_req && !frc && !blk;
    gc = !reset && cpu_req && !gv && !(blk && !cpu_we);
    ev = 1'b0;
    ec = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev = rq[0].vid;
      ec = !rq[0].vid;
      m_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    chk("vid_gnt", vid_gnt, gv);
    chk("cpu_gnt", cpu_gnt, gc);
    chk("sram_a", sram_a, m_a);
    chk("sram_wr", sram_wr, m_wr);
    chk("host_to_sram", host_to_sram, m_hts);
    chk("vid_rvalid", vid_rvalid, ev);
    chk("cpu_rvalid", cpu_rvalid, ec);
    chk("rdata", rdata, m_rdata);
    if (reset) begin
      m_starve = 0;
      m_lastwr = 1'b0;
      m_wr = 1'b0;
      m_a = '0;
      m_hts = '0;
      m_rdata = '0;
      rq.delete();
    end else begin
      m_starve = (!cpu_req || gc) ? 0 : gv ? (m_starve < VB ? m_starve + 1 : VB) : m_starve;
      m_lastwr = gc && cpu_we;
      m_wr = m_lastwr;
      if (gv) begin
        m_a = vid_addr;
        rq.push_back('{cyc + 2, 1'b1, mmem[vid_addr]});
      end
      if (gc) begin
        m_a = cpu_addr;
        if (cpu_we) begin
          m_hts = cpu_wdata;
          mmem[cpu_addr] = cpu_wdata;
        end else rq.push_back('{cyc + 2, 1'b0, mmem[cpu_addr]});
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] va, input bit c, input bit we,
                       input logic [AW-1:0] ca, input logic [15:0] wd);
    vid_req = v;
    vid_addr = va;
    cpu_req = c;
    cpu_we = we;
    cpu_addr = ca;
    cpu_wdata = wd;
  endtask

  initial begin
    logic [9:0] pat;
    pat = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 16'(i) ^ 16'hA5A5;
      mmem[i] = 16'(i) ^ 16'hA5A5;
    end
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    // Single CPU write then read back
    drive(0, '0, 1, 1, 13'h0123, 16'hBEEF);
    #3 chk("t1_wr_gnt", cpu_gnt, 1);
    tick();
    drive(0, '0, 0, 0, '0, '0);
    #3 chk("t1_wr_strobe", sram_wr, 1);
    chk("t1_wr_addr", sram_a, 13'h0123);
    chk("t1_wr_data", host_to_sram, 16'hBEEF);
    tick();
    #3 chk("t1_wr_one_cycle", sram_wr, 0);
    tick();
    drive(0, '0, 1, 0, 13'h0123, '0);
    #3 chk("t1_rd_gnt", cpu_gnt, 1);
    tick();
    drive(0, '0, 0, 0, '0, '0);
    #3 chk("t1_rd_early", cpu_rvalid, 0);
    tick();
    #3 chk("t1_rd_valid", cpu_rvalid, 1);
    chk("t1_rd_data", rdata, 16'hBEEF);
    tick();
    // Contention: both held, expect V,V,V,V,C repeating
    for (int i = 0; i < 10; i++) begin
      drive(1, AW'(13'h0100 + i), 1, 0, 13'h0800, '0);
      #3 pat[i] = cpu_gnt;
      tick();
    end
    drive(0, '0, 0, 0, '0, '0);
    chk("t2_pattern", {22'd0, pat}, 32'h210);
    repeat (3) tick();
    // Turnaround: write then video read
    drive(0, '0, 1, 1, 13'h0200, 16'h1234);
    #3 chk("t3_wr_gnt", cpu_gnt, 1);
    tick();
    drive(1, 13'h0200, 0, 0, '0, '0);
    #3 chk("t3_vid_n1", vid_gnt, !TURN);
    tick();
    vid_req = TURN;
    #3 chk("t3_vid_n2", vid_gnt, TURN);
    tick();
    drive(0, '0, 0, 0, '0, '0);
    repeat (3) tick();
    // Reset in the cycle after a video grant
    drive(1, 13'h0400, 0, 0, '0, '0);
    #3 chk("t4_vid_gnt", vid_gnt, 1);
    tick();
    drive(0, '0, 0, 0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #3 chk("t4_no_rvalid", vid_rvalid, 0);
    chk("t4_sram_a", sram_a, 0);
    chk("t4_sram_wr", sram_wr, 0);
    chk("t4_hts", host_to_sram, 0);
    tick();
    #3 chk("t4_no_rvalid_late", vid_rvalid, 0);
    tick();
    // Idle hold after a read of the top address
    drive(0, '0, 1, 0, 13'h1FFF, '0);
    tick();
    drive(0, '0, 0, 0, '0, '0);
    repeat (3) tick();
    #3 chk("t5_hold_addr", sram_a, 13'h1FFF);
    chk("t5_hold_wr", sram_wr, 0);
    chk("t5_no_cpu_rvalid", cpu_rvalid, 0);
    chk("t5_no_vid_rvalid", vid_rvalid, 0);
    tick();
    // Mixed traffic: writes followed by reads, back-to-back writes, reads of fresh data
    drive(1, 13'h0010, 1, 1, 13'h0020, 16'h5555); tick();
    drive(1, 13'h0011, 1, 1, 13'h0020, 16'h5555); tick();
    drive(0, '0,       1, 1, 13'h0020, 16'h5555); tick();
    drive(1, 13'h0020, 1, 0, 13'h0010, '0);       tick();
    drive(1, 13'h0020, 1, 0, 13'h0010, '0);       tick();
    drive(0, '0,       1, 1, 13'h0030, 16'h7777); tick();
    drive(0, '0,       1, 1, 13'h0031, 16'h8888); tick();
    drive(1, 13'h0031, 1, 0, 13'h0030, '0);       tick();
    drive(0, '0,       1, 0, 13'h0031, '0);       tick();
    drive(0, '0, 0, 0, '0, '0);
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
